dma_bus_arbiter: RTL and testbench

- Owns the shared system bus between the 8080 CPU core and the K580VT57-compatible DMA controller.
- Converts the DMA hold request into a CPU stall at a safe machine-cycle boundary and returns hold-acknowledge to the DMA.
- Muxes address, write data and the four bus strobes to the memory/IO fabric.
- Enforces a minimum CPU slot between DMA tenures and an optional cap on DMA burst length, so video refresh cannot starve the CPU.

---
 rtl/dma_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - system bus arbiter between the 8080 CPU core and the K580VT57 DMA controller
//
// Purpose:
//   Converts a DMA hold request into a CPU stall at a safe machine-cycle
//   boundary, grants the bus to the DMA, and muxes address, write data and
//   strobes onto the shared memory/IO fabric. Every DMA tenure is followed
//   by a one-tick dead cycle (REL) and a guaranteed CPU slot (GUARD), and can
//   optionally be capped in length, so that video refresh cannot starve the CPU.
//
// Parameters:
//   CPU_MIN_SLOTS - ce ticks the CPU keeps the bus after each DMA tenure (0 = none)
//   DMA_MAX_SLOTS - maximum ce ticks per DMA tenure (0 = unlimited)
//
// Build option:
//   ARB_STATS_EN  - when defined, dma_busy_cnt_o counts ce ticks spent in DMA
//                   (saturating; busy_clr_i clears it). Otherwise it is tied to 0.
//
// Ports:
//   clk, reset               - system clock, asynchronous active-high reset
//   ce_i                     - bus-rate clock enable (same strobe as the DMA ce)
//   cpu_sync_i               - CPU is at a machine-cycle boundary
//   cpu_addr_i, cpu_dout_i   - CPU address / write data
//   cpu_*_n_i                - CPU strobes rd/wr/iord/iowr, active-low
//   dma_hrq_i                - DMA hold request
//   dma_addr_i               - DMA address
//   dma_o*_n_i               - DMA strobes ord/owe/oiord/oiowe, active-low
//   busy_clr_i               - clears the DMA ownership counter
//   cpu_hold_o, dma_hlda_o   - CPU stall request / DMA hold acknowledge
//   bus_addr_o, bus_dout_o   - muxed address / write data
//   bus_*_n_o                - muxed strobes, active-low
//   bus_owner_o              - 0 = CPU, 1 = DMA
//   dma_busy_cnt_o           - DMA ownership counter

module dma_bus_arbiter #(
  parameter int unsigned CPU_MIN_SLOTS = 4,
  parameter int unsigned DMA_MAX_SLOTS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_i,
  input  logic        cpu_sync_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_dout_i,
  input  logic        cpu_rd_n_i,
  input  logic        cpu_wr_n_i,
  input  logic        cpu_iord_n_i,
  input  logic        cpu_iowr_n_i,
  input  logic        dma_hrq_i,
  input  logic [15:0] dma_addr_i,
  input  logic        dma_ord_n_i,
  input  logic        dma_owe_n_i,
  input  logic        dma_oiord_n_i,
  input  logic        dma_oiowe_n_i,
  input  logic        busy_clr_i,
  output logic        cpu_hold_o,
  output logic        dma_hlda_o,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_dout_o,
  output logic        bus_rd_n_o,
  output logic        bus_wr_n_o,
  output logic        bus_iord_n_o,
  output logic        bus_iowr_n_o,
  output logic        bus_owner_o,
  output logic [15:0] dma_busy_cnt_o
);

  typedef enum logic [2:0] {
    S_CPU,
    S_HOLD,
    S_DMA,
    S_REL,
    S_GUARD
  } state_e;

  localparam bit          MAX_EN    = (DMA_MAX_SLOTS != 0);
  localparam bit          GUARD_EN  = (CPU_MIN_SLOTS != 0);
  // Terminal slot values; only meaningful when the matching feature is enabled.
  localparam logic [7:0]  DMA_LAST  = 8'(DMA_MAX_SLOTS - 1);
  localparam logic [7:0]  GUARD_LAST = 8'(CPU_MIN_SLOTS - 1);

  state_e     state_q, state_d;
  logic [7:0] slot_q, slot_d;
  logic       cpu_idle;

  assign cpu_idle = cpu_rd_n_i & cpu_wr_n_i & cpu_iord_n_i & cpu_iowr_n_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_CPU;
      slot_q  <= 8'd0;
    end else if (ce_i) begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // Slot counter only runs while staying in DMA or GUARD; every other path
  // (including entry into those states) leaves it at zero.
  always_comb begin
    state_d = state_q;
    slot_d  = 8'd0;
    case (state_q)
      S_CPU: begin
        if (dma_hrq_i) state_d = S_HOLD;
      end
      S_HOLD: begin
        // Withdrawal of hrq takes precedence over a grant on the same tick.
        if (!dma_hrq_i)                  state_d = S_CPU;
        else if (cpu_sync_i && cpu_idle) state_d = S_DMA;
      end
      S_DMA: begin
        if (!dma_hrq_i || (MAX_EN && (slot_q == DMA_LAST))) state_d = S_REL;
        else slot_d = slot_q + 8'd1;
      end
      S_REL: begin
        state_d = GUARD_EN ? S_GUARD : S_CPU;
      end
      S_GUARD: begin
        // hrq is deliberately ignored here: the CPU is owed its slot.
        if (slot_q == GUARD_LAST) state_d = S_CPU;
        else slot_d = slot_q + 8'd1;
      end
      default: state_d = S_CPU;
    endcase
  end

  // Handshake outputs decode directly from the state flops.
  assign cpu_hold_o  = (state_q == S_HOLD) || (state_q == S_DMA) || (state_q == S_REL);
  assign dma_hlda_o  = (state_q == S_DMA);
  assign bus_owner_o = (state_q == S_DMA) || (state_q == S_REL);

  // REL keeps the DMA address stable but parks every strobe, so the two
  // masters never drive strobes in the same clock.
  always_comb begin
    bus_addr_o   = cpu_addr_i;
    bus_dout_o   = cpu_dout_i;
    bus_rd_n_o   = cpu_rd_n_i;
    bus_wr_n_o   = cpu_wr_n_i;
    bus_iord_n_o = cpu_iord_n_i;
    bus_iowr_n_o = cpu_iowr_n_i;
    case (state_q)
      S_DMA: begin
        bus_addr_o   = dma_addr_i;
        bus_dout_o   = 8'h00;
        bus_rd_n_o   = dma_ord_n_i;
        bus_wr_n_o   = dma_owe_n_i;
        bus_iord_n_o = dma_oiord_n_i;
        bus_iowr_n_o = dma_oiowe_n_i;
      end
      S_REL: begin
        bus_addr_o   = dma_addr_i;
        bus_dout_o   = 8'h00;
        bus_rd_n_o   = 1'b1;
        bus_wr_n_o   = 1'b1;
        bus_iord_n_o = 1'b1;
        bus_iowr_n_o = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ARB_STATS_EN
  logic [15:0] busy_q;

  // Clear acts on any clock edge and beats the increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 16'd0;
    end else if (busy_clr_i) begin
      busy_q <= 16'd0;
    end else if (ce_i && (state_q == S_DMA) && (busy_q != 16'hFFFF)) begin
      busy_q <= busy_q + 16'd1;
    end
  end

  assign dma_busy_cnt_o = busy_q;
`else
  logic unused_busy_clr;

  assign unused_busy_clr = busy_clr_i;
  assign dma_busy_cnt_o  = 16'd0;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - self-checking bench for dma_bus_arbiter

module tb_dma_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        cpu_sync = 1'b1;
  logic [15:0] cpu_addr = 16'h1234;
  logic [7:0]  cpu_dout = 8'hA5;
  logic        cpu_rd_n = 1'b1, cpu_wr_n = 1'b1, cpu_iord_n = 1'b1, cpu_iowr_n = 1'b1;
  logic        dma_hrq = 1'b0;
  logic [15:0] dma_addr = 16'hE000;
  logic        dma_ord_n = 1'b0, dma_owe_n = 1'b1, dma_oiord_n = 1'b1, dma_oiowe_n = 1'b1;
  logic        busy_clr = 1'b0;
  logic        cpu_hold, dma_hlda, bus_owner;
  logic [15:0] bus_addr, dma_busy_cnt;
  logic [7:0]  bus_dout;
  logic        bus_rd_n, bus_wr_n, bus_iord_n, bus_iowr_n;

  dma_bus_arbiter #(.CPU_MIN_SLOTS(4), .DMA_MAX_SLOTS(8)) dut (
    .clk(clk), .reset(reset), .ce_i(ce), .cpu_sync_i(cpu_sync),
    .cpu_addr_i(cpu_addr), .cpu_dout_i(cpu_dout),
    .cpu_rd_n_i(cpu_rd_n), .cpu_wr_n_i(cpu_wr_n), .cpu_iord_n_i(cpu_iord_n), .cpu_iowr_n_i(cpu_iowr_n),
    .dma_hrq_i(dma_hrq), .dma_addr_i(dma_addr),
    .dma_ord_n_i(dma_ord_n), .dma_owe_n_i(dma_owe_n), .dma_oiord_n_i(dma_oiord_n), .dma_oiowe_n_i(dma_oiowe_n),
    .busy_clr_i(busy_clr),
    .cpu_hold_o(cpu_hold), .dma_hlda_o(dma_hlda),
    .bus_addr_o(bus_addr), .bus_dout_o(bus_dout),
    .bus_rd_n_o(bus_rd_n), .bus_wr_n_o(bus_wr_n), .bus_iord_n_o(bus_iord_n), .bus_iowr_n_o(bus_iowr_n),
    .bus_owner_o(bus_owner), .dma_busy_cnt_o(dma_busy_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] K_CPU = 2'd0, K_HOLD = 2'd1, K_DMA = 2'd2, K_REL = 2'd3;

  typedef struct packed {
    logic       hrq;
    logic       sync;
    logic [3:0] st;
    logic [1:0] kind;
  } step_t;

  typedef struct packed {
    logic        hold;
    logic        hlda;
    logic        owner;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [3:0]  st;
  } obs_t;

  step_t plan[$];
  obs_t  exp_q[$];
  obs_t  got, exp;
  int    n_checks = 0;
  int    n_fails = 0;

  function automatic obs_t expect_of(input logic [1:0] k);
    case (k)
      K_CPU:   return {1'b0, 1'b0, 1'b0, cpu_addr, cpu_dout, cpu_rd_n, cpu_wr_n, cpu_iord_n, cpu_iowr_n};
      K_HOLD:  return {1'b1, 1'b0, 1'b0, cpu_addr, cpu_dout, cpu_rd_n, cpu_wr_n, cpu_iord_n, cpu_iowr_n};
      K_DMA:   return {1'b1, 1'b1, 1'b1, dma_addr, 8'h00, dma_ord_n, dma_owe_n, dma_oiord_n, dma_oiowe_n};
      default: return {1'b1, 1'b0, 1'b1, dma_addr, 8'h00, 4'hF};
    endcase
  endfunction

  function automatic obs_t observe();
    return {cpu_hold, dma_hlda, bus_owner, bus_addr, bus_dout, bus_rd_n, bus_wr_n, bus_iord_n, bus_iowr_n};
  endfunction

  task automatic add(input logic hrq, input logic sync, input logic [3:0] st, input logic [1:0] k);
    step_t s;
    s = {hrq, sync, st, k};
    plan.push_back(s);
  endtask

  // One ce tick: one idle clock with ce low, one clock with ce high, sample #1 after.
  task automatic tick();
    @(posedge clk);
    #1 ce = 1'b1;
    @(posedge clk);
    #1 ce = 1'b0;
  endtask

  task automatic apply(input step_t s);
    dma_hrq  = s.hrq;
    cpu_sync = s.sync;
    {cpu_rd_n, cpu_wr_n, cpu_iord_n, cpu_iowr_n} = s.st;
  endtask

  task automatic test_reset();
    cpu_rd_n = 1'b0;
    #2;
    got = observe();
    exp = expect_of(K_CPU);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL reset_outputs: got %h expected %h", got, exp);
    end
    n_checks++;
    if (dma_busy_cnt !== 16'd0) begin
      n_fails++;
      $display("FAIL reset_busy_cnt: got %h expected 0000", dma_busy_cnt);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_idle();
    plan.delete();
    add(1'b0, 1'b1, 4'h7, K_CPU);
    add(1'b0, 1'b1, 4'h7, K_CPU);
    add(1'b0, 1'b1, 4'hF, K_CPU);
    add(1'b0, 1'b0, 4'hB, K_CPU);
    add(1'b0, 1'b1, 4'hE, K_CPU);
    for (int i = 0; i < plan.size(); i++) begin
      apply(plan[i]);
      exp_q.push_back(expect_of(plan[i].kind));
      tick();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL idle step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_basic_grant();
    plan.delete();
    dma_ord_n = 1'b0; dma_owe_n = 1'b1; dma_oiord_n = 1'b1; dma_oiowe_n = 1'b1;
    add(1'b1, 1'b1, 4'hF, K_HOLD);
    add(1'b1, 1'b1, 4'hF, K_DMA);
    add(1'b1, 1'b1, 4'hF, K_DMA);
    add(1'b0, 1'b1, 4'hF, K_REL);
    for (int j = 0; j < 5; j++) add(1'b0, 1'b1, 4'hF, K_CPU);
    for (int i = 0; i < plan.size(); i++) begin
      apply(plan[i]);
      exp_q.push_back(expect_of(plan[i].kind));
      tick();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL basic_grant step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_deferred_grant();
    plan.delete();
    for (int j = 0; j < 3; j++) add(1'b1, 1'b0, 4'hB, K_HOLD);
    add(1'b1, 1'b1, 4'hB, K_HOLD);
    add(1'b1, 1'b0, 4'hF, K_HOLD);
    add(1'b1, 1'b1, 4'hF, K_DMA);
    add(1'b0, 1'b1, 4'hF, K_REL);
    for (int j = 0; j < 5; j++) add(1'b0, 1'b1, 4'hF, K_CPU);
    for (int i = 0; i < plan.size(); i++) begin
      apply(plan[i]);
      exp_q.push_back(expect_of(plan[i].kind));
      tick();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL deferred_grant step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_release_guard();
    plan.delete();
    add(1'b1, 1'b1, 4'hF, K_HOLD);
    for (int j = 0; j < 5; j++) add(1'b1, 1'b1, 4'hF, K_DMA);
    add(1'b0, 1'b1, 4'hF, K_REL);
    // hrq back high at once: 4 GUARD ticks plus the CPU tick that samples it.
    for (int j = 0; j < 5; j++) add(1'b1, 1'b1, 4'hF, K_CPU);
    add(1'b1, 1'b1, 4'hF, K_HOLD);
    add(1'b1, 1'b1, 4'hF, K_DMA);
    add(1'b0, 1'b1, 4'hF, K_REL);
    for (int j = 0; j < 5; j++) add(1'b0, 1'b1, 4'hF, K_CPU);
    for (int i = 0; i < plan.size(); i++) begin
      apply(plan[i]);
      exp_q.push_back(expect_of(plan[i].kind));
      tick();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL release_guard step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_abort();
    plan.delete();
    add(1'b1, 1'b0, 4'hB, K_HOLD);
    add(1'b0, 1'b0, 4'hB, K_CPU);
    add(1'b0, 1'b1, 4'hF, K_CPU);
    add(1'b1, 1'b1, 4'hF, K_HOLD);
    add(1'b0, 1'b1, 4'hF, K_CPU);
    add(1'b0, 1'b1, 4'hF, K_CPU);
    for (int i = 0; i < plan.size(); i++) begin
      apply(plan[i]);
      exp_q.push_back(expect_of(plan[i].kind));
      tick();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL abort step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_burst_cap();
    logic [15:0] exp_busy;
`ifdef ARB_STATS_EN
    exp_busy = 16'd8;
`else
    exp_busy = 16'd0;
`endif
    busy_clr = 1'b1;
    tick();
    busy_clr = 1'b0;
    n_checks++;
    if (dma_busy_cnt !== 16'd0) begin
      n_fails++;
      $display("FAIL busy_clear: got %h expected 0000", dma_busy_cnt);
    end
    dma_ord_n = 1'b1; dma_owe_n = 1'b0; dma_oiord_n = 1'b1; dma_oiowe_n = 1'b1;
    plan.delete();
    add(1'b1, 1'b1, 4'hF, K_HOLD);
    for (int j = 0; j < 8; j++) add(1'b1, 1'b1, 4'hF, K_DMA);
    add(1'b1, 1'b1, 4'hF, K_REL);
    for (int j = 0; j < 5; j++) add(1'b1, 1'b1, 4'hF, K_CPU);
    add(1'b1, 1'b1, 4'hF, K_HOLD);
    add(1'b1, 1'b1, 4'hF, K_DMA);
    add(1'b0, 1'b1, 4'hF, K_REL);
    for (int j = 0; j < 5; j++) add(1'b0, 1'b1, 4'hF, K_CPU);
    for (int i = 0; i < plan.size(); i++) begin
      apply(plan[i]);
      exp_q.push_back(expect_of(plan[i].kind));
      tick();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL burst_cap step %0d: got %h expected %h", i, got, exp);
      end
      if (i == 9) begin
        n_checks++;
        if (dma_busy_cnt !== exp_busy) begin
          n_fails++;
          $display("FAIL burst_busy_cnt: got %h expected %h", dma_busy_cnt, exp_busy);
        end
      end
    end
  endtask

  task automatic test_reset_mid_tenure();
    dma_ord_n = 1'b0; dma_owe_n = 1'b1; dma_oiord_n = 1'b1; dma_oiowe_n = 1'b1;
    plan.delete();
    add(1'b1, 1'b1, 4'hF, K_HOLD);
    add(1'b1, 1'b1, 4'hF, K_DMA);
    for (int i = 0; i < plan.size(); i++) begin
      apply(plan[i]);
      exp_q.push_back(expect_of(plan[i].kind));
      tick();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL mid_reset_setup step %0d: got %h expected %h", i, got, exp);
      end
    end
    cpu_wr_n = 1'b0;
    #2 reset = 1'b1;
    #1;
    got = observe();
    exp = expect_of(K_CPU);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL mid_reset_async: got %h expected %h", got, exp);
    end
    tick();
    @(posedge clk);
    #1 reset = 1'b0;
    dma_hrq = 1'b0;
    cpu_wr_n = 1'b1;
    exp_q.push_back(expect_of(K_CPU));
    tick();
    got = observe();
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL mid_reset_after: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_basic_grant();
    test_deferred_grant();
    test_release_guard();
    test_abort();
    test_burst_cap();
    test_reset_mid_tenure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
